mux_4_to_1: RTL and testbench
=============================

Name: mux_4_to_1

Overview:
- Four-input, WIDTH-bit multiplexer built from gate-level AND/OR logic.
- The combinational output y follows the data inputs and sel with zero-cycle latency.
- A registered copy y_q gives downstream synchronous logic a one-cycle-delayed, reset-controlled version.
- Used as a generic datapath selector in small DSP front-end blocks.

Parameters:
- WIDTH, 4, bit width of each data input and of each output.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  synchronous reset, active-high.
- d0  input  WIDTH  data input, selected when sel=0.
- d1  input  WIDTH  data input, selected when sel=1.
- d2  input  WIDTH  data input, selected when sel=2.
- d3  input  WIDTH  data input, selected when sel=3.
- sel  input  2  select code.
- y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  registered mux output.

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Selection: y = d0, d1, d2, d3 for sel = 0, 1, 2, 3 respectively.
- y is purely combinational from d0..d3 and sel; it settles within the same delta/time step.
- y is independent of clk and rst, including while rst is high.
- Gate-level realisation is mandatory, not a behavioural case/ternary:
  - Decode sel into four one-hot enables (sel1' sel0', sel1' sel0, sel1 sel0', sel1 sel0).
  - Per bit: y[i] = OR over k of (en_k AND dk[i]).
- X-handling follows from the gate form:
  - X/Z on an unselected input must not reach y; its AND term is forced to 0.
  - X on the selected input propagates to y as X, bit-for-bit.
  - X/Z on sel gives an undefined y; nothing more is required.
- y_q behaviour on each rising clk:
  - rst=1: y_q <= 0.
  - Otherwise: y_q <= y.
  - Latency is one cycle; y_q resets to all-zero.
- Before the first clock edge with rst asserted, y_q is unspecified.
- Reset taking effect mid-stream clears y_q on that same edge; y is unaffected.
- sel changing every cycle: y_q tracks the value of y sampled at each edge. There is no hold state and no handshake.

Optional Feature:
- Macro: MUX_4_TO_1_PARITY_EN.
- When defined, two extra 1-bit outputs are added:
  - y_par = XOR-reduction of y (even-parity bit), combinational.
  - y_q_par: registered with y_q, reset to 0.
- When undefined, both ports and their logic are absent. All other behaviour is unchanged.

Decomposition:
- Package mux_4_to_1_pkg:
  - Localparam DEFAULT_WIDTH = 4.
  - 2-bit sel typedef with named codes SEL_D0..SEL_D3 (0..3).
- One sub-module, mux_4_to_1_decode: 2-to-4 one-hot enable decoder built from NOT/AND gates.
- The AND-OR plane, y_q register and optional parity logic stay in the top module.

Test Plan:
- d0..d3 = a, b, c, d (hex), sel swept 0→3 -> y = a, b, c, d; after the next clock edge, y_q equals each value.
- d0=7, d1=10, d2=3, d3=X, sel = 0, 1, 2 -> y = 7, 10, 3 exactly, no X bits. sel=3 -> y = X (checked with case inequality).
- rst=1 for one edge with sel=1, d1=F -> y_q = 0 after the edge while y = F. Deassert rst -> y_q = F on the next edge.
- sel toggles 0/3 every cycle with d0=5, d3=9 -> y_q alternates 5, 9 lagging y by exactly one cycle.
- Reset asserted mid-sequence -> y_q = 0 on that edge; y keeps tracking the inputs.
- With MUX_4_TO_1_PARITY_EN defined, sel=2, d2=7 -> y_par = 1 immediately; y_q_par = 1 after one edge; y_q_par = 0 under reset.

Source files
------------

// File: rtl/mux_4_to_1_pkg.sv
// mux_4_to_1_pkg: shared width default and select codes for the 4:1 mux slice.
package mux_4_to_1_pkg;
    localparam int DEFAULT_WIDTH = 4;
    typedef enum logic [1:0] {
        SEL_D0 = 2'd0,
        SEL_D1 = 2'd1,
        SEL_D2 = 2'd2,
        SEL_D3 = 2'd3
    } sel_t;
endpackage

// File: rtl/mux_4_to_1_decode.sv
// mux_4_to_1_decode: 2-to-4 one-hot enable decoder from NOT/AND gates.
module mux_4_to_1_decode (
    input  logic [1:0] sel,
    output logic [3:0] en
);
    logic s0_n, s1_n;
    not u_n0 (s0_n, sel[0]);
    not u_n1 (s1_n, sel[1]);
    and u_e0 (en[0], s1_n, s0_n);
    and u_e1 (en[1], s1_n, sel[0]);
    and u_e2 (en[2], sel[1], s0_n);
    and u_e3 (en[3], sel[1], sel[0]);
endmodule

// File: rtl/mux_4_to_1.sv
// mux_4_to_1: gate-level AND-OR 4:1 mux with registered copy y_q.
// Optional even-parity outputs y_par/y_q_par when MUX_4_TO_1_PARITY_EN is defined.
module mux_4_to_1
    import mux_4_to_1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
`ifdef MUX_4_TO_1_PARITY_EN
    output logic             y_par,
    output logic             y_q_par,
`endif
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);
    logic [3:0] en;

    mux_4_to_1_decode u_decode (
        .sel(sel),
        .en (en)
    );

    // A deselected input is ANDed with 0, so X/Z on it never reaches y.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [3:0] t;
        and u_a0 (t[0], en[0], d0[i]);
        and u_a1 (t[1], en[1], d1[i]);
        and u_a2 (t[2], en[2], d2[i]);
        and u_a3 (t[3], en[3], d3[i]);
        or  u_o  (y[i], t[0], t[1], t[2], t[3]);
    end

    always_ff @(posedge clk)
        y_q <= rst ? '0 : y;

`ifdef MUX_4_TO_1_PARITY_EN
    assign y_par = ^y;

    always_ff @(posedge clk)
        y_q_par <= rst ? 1'b0 : y_par;
`endif
endmodule

// File: tb/tb_mux_4_to_1.sv
// tb_mux_4_to_1: directed self-checking bench for the 4:1 mux and its register.
module tb_mux_4_to_1;
    import mux_4_to_1_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic [1:0] sel = SEL_D0;
    logic [3:0] y, y_q;
`ifdef MUX_4_TO_1_PARITY_EN
    logic       y_par, y_q_par;
`endif
    int checks = 0;
    int errors = 0;

    mux_4_to_1 #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .d0(d0),
        .d1(d1),
        .d2(d2),
        .d3(d3),
        .sel(sel),
`ifdef MUX_4_TO_1_PARITY_EN
        .y_par(y_par),
        .y_q_par(y_q_par),
`endif
        .y(y),
        .y_q(y_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] prev;
    logic [3:0] abcd [4];

    initial begin
        abcd[0] = 4'hA; abcd[1] = 4'hB; abcd[2] = 4'hC; abcd[3] = 4'hD;
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
        sel = SEL_D0;
        rst = 1'b1;
        tick();
        chk("reset_yq", y_q, 4'h0);
        chk("y_during_rst", y, 4'hA);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            chk($sformatf("sweep_y%0d", k), y, abcd[k]);
            tick();
            chk($sformatf("sweep_yq%0d", k), y_q, abcd[k]);
        end

        d0 = 4'h7; d1 = 4'hA; d2 = 4'h3; d3 = 4'bxxxx;
        sel = SEL_D0; #1; chk("x_unsel_s0", y, 4'h7);
        sel = SEL_D1; #1; chk("x_unsel_s1", y, 4'hA);
        sel = SEL_D2; #1; chk("x_unsel_s2", y, 4'h3);
        sel = SEL_D3; #1; chk("x_sel_s3", y, 4'bxxxx);

        d3 = 4'h0; d1 = 4'hF; sel = SEL_D1; rst = 1'b1;
        tick();
        chk("rst_yq", y_q, 4'h0);
        chk("rst_y", y, 4'hF);
        rst = 1'b0;
        tick();
        chk("post_rst_yq", y_q, 4'hF);

        d0 = 4'h5; d3 = 4'h9;
        prev = 4'hF;
        for (int k = 0; k < 6; k++) begin
            sel = (k % 2 == 1) ? SEL_D3 : SEL_D0;
            #1;
            chk($sformatf("tog_y%0d", k), y, (k % 2 == 1) ? 4'h9 : 4'h5);
            chk($sformatf("tog_lag%0d", k), y_q, prev);
            tick();
            chk($sformatf("tog_yq%0d", k), y_q, (k % 2 == 1) ? 4'h9 : 4'h5);
            prev = (k % 2 == 1) ? 4'h9 : 4'h5;
        end

        sel = SEL_D3; rst = 1'b1;
        tick();
        chk("mid_rst_yq", y_q, 4'h0);
        chk("mid_rst_y", y, 4'h9);
        sel = SEL_D0; #1;
        chk("mid_rst_track", y, 4'h5);
        rst = 1'b0;
        tick();
        chk("mid_rst_release", y_q, 4'h5);

`ifdef MUX_4_TO_1_PARITY_EN
        d2 = 4'h7; sel = SEL_D2; #1;
        chk("par_y", {3'b0, y_par}, 4'h1);
        tick();
        chk("par_yq", {3'b0, y_q_par}, 4'h1);
        d2 = 4'h3; #1;
        chk("par_even", {3'b0, y_par}, 4'h0);
        d2 = 4'h7; rst = 1'b1;
        tick();
        chk("par_rst", {3'b0, y_q_par}, 4'h0);
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
